// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared playfield dimensions, board/row types and the line-clear FSM state
// encoding used by row_clear_ctrl and board_row_shift.
//   BLOCKS_WIDE : cells per row (14)
//   BLOCKS_HIGH : rows per board (18)
//   BOARD_BITS  : flattened board width, row r at [BLOCKS_WIDE*r +: BLOCKS_WIDE]
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam int BLOCKS_WIDE = 14;
  localparam int BLOCKS_HIGH = 18;
  localparam int BOARD_BITS  = BLOCKS_WIDE * BLOCKS_HIGH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [4:0] row_t;

endpackage

// File: rtl/board_row_shift.sv
// -----------------------------------------------------------------------------
// board_row_shift
// Combinational row removal: deletes row `row` from the board, moves every row
// above it down by one, and fills row 0 (the top) with empty cells. Rows below
// `row` pass through untouched.
// Ports:
//   board_in  : board before removal (row 0 = top)
//   row       : index of the row to remove
//   board_out : board after removal
// -----------------------------------------------------------------------------
module board_row_shift
  import tetris_pkg::*;
(
  input  logic [BOARD_BITS-1:0] board_in,
  input  row_t                  row,
  output logic [BOARD_BITS-1:0] board_out
);

  always_comb begin
    board_out = board_in;
    for (int r = 0; r < BLOCKS_HIGH; r++) begin
      if (r == 0) begin
        // The top row always becomes empty, even when row 0 itself is removed.
        board_out[0 +: BLOCKS_WIDE] = '0;
      end else if (r <= int'(row)) begin
        board_out[r*BLOCKS_WIDE +: BLOCKS_WIDE] = board_in[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  end

endmodule

// File: rtl/row_clear_ctrl.sv
// -----------------------------------------------------------------------------
// row_clear_ctrl
// Line-clear sequencer. On an accepted Start it snapshots the landed board,
// scans rows bottom-up one per cycle, removes each full row (shifting the rows
// above down) and re-checks the same row index, then pulses Done.
// Ports:
//   Clk, Rst_n    : clock (rising edge), async active-low reset
//   Pause         : freezes every register while high
//   Start         : one-cycle request, accepted only in IDLE without Pause
//   Game_in       : landed board from piece-lock logic
//   Game_out      : internal board register (cleaned board when Done)
//   Busy          : high in SCAN, SHIFT and DONE
//   Done          : high for the single DONE cycle (held while paused)
//   Lines_cleared : rows removed in the current/last pass
//   Total_lines   : saturating total of removed rows since reset
// -----------------------------------------------------------------------------
module row_clear_ctrl
  import tetris_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Pause,
  input  logic                  Start,
  input  logic [BOARD_BITS-1:0] Game_in,
  output logic [BOARD_BITS-1:0] Game_out,
  output logic                  Busy,
  output logic                  Done,
  output logic [4:0]            Lines_cleared,
  output logic [15:0]           Total_lines
);

  state_t                  state_q, state_d;
  row_t                    row_q, row_d;
  logic [BOARD_BITS-1:0]   board_d;
  logic [BOARD_BITS-1:0]   shifted;
  logic [4:0]              lines_d;
  logic [15:0]             total_d;
  logic                    busy_d, done_d;
  logic                    row_full;

  board_row_shift u_shift (
    .board_in  (Game_out),
    .row       (row_q),
    .board_out (shifted)
  );

  assign row_full = &Game_out[row_q*BLOCKS_WIDE +: BLOCKS_WIDE];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      row_q         <= '0;
      Game_out      <= '0;
      Lines_cleared <= '0;
      Total_lines   <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      Game_out      <= board_d;
      Lines_cleared <= lines_d;
      Total_lines   <= total_d;
      Busy          <= busy_d;
      Done          <= done_d;
    end
  end

  // Everything defaults to hold, so Pause simply skips the state update.
  // Busy/Done are derived from the next state so they are registered outputs.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    board_d = Game_out;
    lines_d = Lines_cleared;
    total_d = Total_lines;

    if (!Pause) begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            board_d = Game_in;
            row_d   = row_t'(BLOCKS_HIGH - 1);
            lines_d = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            state_d = SHIFT;
          end else if (row_q == '0) begin
            state_d = DONE;
          end else begin
            row_d = row_q - 5'd1;
          end
        end
        SHIFT: begin
          // Row index is kept so the row that dropped in is re-checked.
          board_d = shifted;
          lines_d = Lines_cleared + 5'd1;
          if (Total_lines != 16'hFFFF) begin
            total_d = Total_lines + 16'd1;
          end
          state_d = SCAN;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule
